// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master to one-slave Wishbone B4 classic arbiter.
// Whole-cycle (cyc-locked) round-robin grant, plus a strobe timeout that returns err to the owner.
module wb_arbiter #(
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    output logic                    m0_rty_o,

    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic                    m1_rty_o,

    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_rty_i,

    output logic [1:0]              grant_o
);

    localparam int unsigned CNT_W = (TIMEOUT != 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        M0   = 2'd1,
        M1   = 2'd2
    } owner_t;

    owner_t           owner, owner_nxt, last, cur;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             tmo, tmo_nxt, tmo_act, waiting;

    // Reset masks the bus immediately, so an aborted cycle sends no termination.
    assign cur     = rst_i ? IDLE : owner;
    assign tmo_act = tmo & ~rst_i;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = {cur == M1, cur == M0};

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_sel_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        case (cur)
            M0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~tmo_act;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_sel_o  = m0_sel_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i & ~tmo_act;
                m0_err_o = s_err_i | tmo_act;
                m0_rty_o = s_rty_i & ~tmo_act;
            end
            M1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~tmo_act;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_sel_o  = m1_sel_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i & ~tmo_act;
                m1_err_o = s_err_i | tmo_act;
                m1_rty_o = s_rty_i & ~tmo_act;
            end
            default: ;
        endcase
    end

    assign waiting = s_cyc_o & s_stb_o & ~(s_ack_i | s_err_i | s_rty_i);

    always_comb begin
        owner_nxt = owner;
        case (owner)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    owner_nxt = (last == M1) ? M0 : M1;
                else if (m0_cyc_i)
                    owner_nxt = M0;
                else if (m1_cyc_i)
                    owner_nxt = M1;
            end
            M0:      if (!m0_cyc_i) owner_nxt = IDLE;
            M1:      if (!m1_cyc_i) owner_nxt = IDLE;
            default: owner_nxt = IDLE;
        endcase

        // Forcing stb low during the tmo cycle clears the counter without a separate path.
        cnt_nxt = '0;
        tmo_nxt = 1'b0;
        if (TIMEOUT != 0 && waiting && owner_nxt == owner) begin
            cnt_nxt = cnt + CNT_W'(1);
            tmo_nxt = (cnt == CNT_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner <= IDLE;
            last  <= M1;
            cnt   <= '0;
            tmo   <= 1'b0;
        end else begin
            owner <= owner_nxt;
            if (owner == IDLE && owner_nxt != IDLE)
                last <= owner_nxt;
            cnt <= cnt_nxt;
            tmo <= tmo_nxt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: stimulus pushes expected bus events, a negedge monitor compares them.
// A second instance with TIMEOUT = 0 sits on an unanswered strobe to show no err is ever produced.
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, m0_dat_o, m1_dat_o;
    logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [1:0]  grant_o;

    logic        z_m0_cyc_i, z_m0_stb_i;
    logic [31:0] z_m0_adr_i, z_m0_dat_o, z_m1_dat_o, z_s_adr_o, z_s_dat_o;
    logic [3:0]  z_s_sel_o;
    logic        z_m0_ack_o, z_m0_err_o, z_m0_rty_o, z_m1_ack_o, z_m1_err_o, z_m1_rty_o;
    logic        z_s_cyc_o, z_s_stb_o, z_s_we_o;
    logic [1:0]  z_grant_o;

    wb_arbiter #(.TIMEOUT(8), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
        .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    wb_arbiter #(.TIMEOUT(0), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut_notmo (
        .clk_i(clk), .rst_i(rst_i),
        .m0_cyc_i(z_m0_cyc_i), .m0_stb_i(z_m0_stb_i), .m0_we_i(1'b0), .m0_adr_i(z_m0_adr_i),
        .m0_sel_i(4'hF), .m0_dat_i(32'h0), .m0_dat_o(z_m0_dat_o),
        .m0_ack_o(z_m0_ack_o), .m0_err_o(z_m0_err_o), .m0_rty_o(z_m0_rty_o),
        .m1_cyc_i(1'b0), .m1_stb_i(1'b0), .m1_we_i(1'b0), .m1_adr_i(32'h0),
        .m1_sel_i(4'h0), .m1_dat_i(32'h0), .m1_dat_o(z_m1_dat_o),
        .m1_ack_o(z_m1_ack_o), .m1_err_o(z_m1_err_o), .m1_rty_o(z_m1_rty_o),
        .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o), .s_we_o(z_s_we_o), .s_adr_o(z_s_adr_o),
        .s_sel_o(z_s_sel_o), .s_dat_o(z_s_dat_o), .s_dat_i(32'h0),
        .s_ack_i(1'b0), .s_err_i(1'b0), .s_rty_i(1'b0),
        .grant_o(z_grant_o)
    );

    typedef struct packed {
        int unsigned cyc;
        logic [1:0]  g;
        logic [2:0]  t0;    // {ack, err, rty} seen by m0
        logic [2:0]  t1;
        logic [2:0]  cse;   // {s_cyc, s_stb, s_we}
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } ev_t;

    ev_t         expq[$];
    int unsigned cyc_n = 0;
    logic        end_req;
    logic [2:0]  rr_term [4] = '{3'b100, 3'b010, 3'b001, 3'b110};

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
        m0_cyc_i = c; m0_stb_i = s; m0_we_i = w; m0_adr_i = a; m0_dat_i = d; m0_sel_i = 4'hF;
    endtask

    task automatic set_m1(input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
        m1_cyc_i = c; m1_stb_i = s; m1_we_i = w; m1_adr_i = a; m1_dat_i = d; m1_sel_i = 4'h3;
    endtask

    task automatic slave(input logic [2:0] t, input logic [31:0] d);
        {s_ack_i, s_err_i, s_rty_i} = t;
        s_dat_i = d;
    endtask

    // Expected event in the current cycle; slave-side fields come from the owner's driven inputs.
    function automatic void push(input logic [1:0] g, input logic [2:0] t0, input logic [2:0] t1, input logic kill);
        ev_t e;
        e = '0;
        e.cyc = cyc_n; e.g = g; e.t0 = t0; e.t1 = t1;
        if (g == 2'b01) begin
            e.cse = {m0_cyc_i, m0_stb_i & ~kill, m0_we_i};
            e.adr = m0_adr_i; e.sel = m0_sel_i; e.wd = m0_dat_i;
        end else if (g == 2'b10) begin
            e.cse = {m1_cyc_i, m1_stb_i & ~kill, m1_we_i};
            e.adr = m1_adr_i; e.sel = m1_sel_i; e.wd = m1_dat_i;
        end
        e.rd0 = s_dat_i;
        e.rd1 = s_dat_i;
        expq.push_back(e);
    endfunction

    initial begin
        end_req = 1'b0;
        rst_i   = 1'b1;
        set_m0(1'b1, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
        set_m1(1'b1, 1'b1, 1'b1, 32'h3000_0000, 32'h1111_1111);
        slave(3'b000, 32'h0);
        z_m0_cyc_i = 1'b1; z_m0_stb_i = 1'b1; z_m0_adr_i = 32'h4000_0000;
        repeat (3) nxt();
        rst_i = 1'b0;

        // m0 wins the first tie, single read; then m1 gets the bus after one idle cycle
        nxt(); push(2'b01, 3'b000, 3'b000, 1'b0);
        nxt(); slave(3'b100, 32'hDEAD_BEEF); push(2'b01, 3'b100, 3'b000, 1'b0);
        nxt(); slave(3'b000, 32'h0); set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        nxt(); push(2'b00, 3'b000, 3'b000, 1'b0);
        nxt(); slave(3'b100, 32'h5555_AAAA); push(2'b10, 3'b000, 3'b100, 1'b0);
        nxt(); slave(3'b000, 32'h0); set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        nxt(); push(2'b00, 3'b000, 3'b000, 1'b0);
        nxt();

        // four rounds of simultaneous requests: 01, 10, 01, 10 with one idle cycle between
        set_m0(1'b1, 1'b1, 1'b0, 32'h2000_0010, 32'h0);
        set_m1(1'b1, 1'b1, 1'b0, 32'h3000_0010, 32'h0);
        for (int r = 0; r < 4; r++) begin
            nxt();
            slave(rr_term[r], 32'hA5A5_0000 + 32'(r));
            if (r % 2 == 0) push(2'b01, rr_term[r], 3'b000, 1'b0);
            else            push(2'b10, 3'b000, rr_term[r], 1'b0);
            nxt();
            slave(3'b000, 32'h0);
            set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            nxt();
            push(2'b00, 3'b000, 3'b000, 1'b0);
            if (r < 3) begin
                set_m0(1'b1, 1'b1, 1'b0, 32'h2000_0011 + 32'(r), 32'h0);
                set_m1(1'b1, 1'b1, 1'b0, 32'h3000_0011 + 32'(r), 32'h0);
            end
        end

        // m1 holds cyc over three write phases; m0 waits until m1 releases
        nxt(); set_m1(1'b1, 1'b1, 1'b1, 32'h2000_0000, 32'hC0DE_0000);
        nxt(); set_m0(1'b1, 1'b1, 1'b0, 32'h2000_0100, 32'h0); slave(3'b100, 32'h0);
        push(2'b10, 3'b000, 3'b100, 1'b0);
        nxt(); slave(3'b000, 32'h0); m1_stb_i = 1'b0;
        nxt(); set_m1(1'b1, 1'b1, 1'b1, 32'h2000_0004, 32'hC0DE_0001); slave(3'b001, 32'h0);
        push(2'b10, 3'b000, 3'b001, 1'b0);
        nxt(); set_m1(1'b1, 1'b1, 1'b1, 32'h2000_0008, 32'hC0DE_0002); slave(3'b100, 32'h0);
        push(2'b10, 3'b000, 3'b100, 1'b0);
        nxt(); set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); slave(3'b000, 32'h0);
        nxt(); push(2'b00, 3'b000, 3'b000, 1'b0);
        nxt(); slave(3'b100, 32'h0BAD_F00D); push(2'b01, 3'b100, 3'b000, 1'b0);
        nxt(); slave(3'b000, 32'h0); set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        nxt(); push(2'b00, 3'b000, 3'b000, 1'b0);
        nxt();

        // TIMEOUT = 8: err 9 cycles after cyc+stb; re-strobe acked on wait cycle 8 gets no err
        set_m0(1'b1, 1'b1, 1'b0, 32'h4000_0000, 32'h0);
        nxt(); push(2'b01, 3'b000, 3'b000, 1'b0);
        repeat (8) nxt();
        push(2'b01, 3'b010, 3'b000, 1'b1);
        nxt(); m0_stb_i = 1'b0;
        nxt(); set_m0(1'b1, 1'b1, 1'b0, 32'h4000_0004, 32'h0);
        repeat (7) nxt();
        slave(3'b100, 32'h1234_5678); push(2'b01, 3'b100, 3'b000, 1'b0);
        nxt(); slave(3'b000, 32'h0); set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        nxt(); push(2'b00, 3'b000, 3'b000, 1'b0);

        // the TIMEOUT = 0 instance has been strobing an absent slave since reset
        repeat (2000) nxt();
        end_req = 1'b1;
    end

    initial begin
        ev_t         a, e;
        logic [1:0]  prev_g;
        int unsigned n_cmp, n_fail, z_err_cnt;
        n_cmp = 0; n_fail = 0; z_err_cnt = 0; prev_g = 2'b00;
        forever begin
            @(negedge clk);
            if (end_req) begin
                while (expq.size() > 0) begin
                    e = expq.pop_front();
                    n_cmp++; n_fail++;
                    $display("FAIL missing_event: got none, want cyc=%0d g=%b t0=%b t1=%b", e.cyc, e.g, e.t0, e.t1);
                end
                n_cmp++;
                if (z_err_cnt != 0) begin
                    n_fail++;
                    $display("FAIL notmo_err_count: got %0d, want 0", z_err_cnt);
                end
                n_cmp++;
                if (z_grant_o !== 2'b01) begin
                    n_fail++;
                    $display("FAIL notmo_grant: got %b, want 01", z_grant_o);
                end
                n_cmp++;
                if (z_s_stb_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL notmo_stb: got %b, want 1", z_s_stb_o);
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $finish;
            end else if (rst_i) begin
                n_cmp++;
                if ({grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
                     m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_outputs @%0d: got g=%b cse=%b adr=%h sel=%h wd=%h t0=%b t1=%b, want all 0",
                             cyc_n, grant_o, {s_cyc_o, s_stb_o, s_we_o}, s_adr_o, s_sel_o, s_dat_o,
                             {m0_ack_o, m0_err_o, m0_rty_o}, {m1_ack_o, m1_err_o, m1_rty_o});
                end
                prev_g = 2'b00;
            end else begin
                if (z_m0_err_o === 1'b1) z_err_cnt++;
                a = '{cyc: cyc_n, g: grant_o, t0: {m0_ack_o, m0_err_o, m0_rty_o},
                      t1: {m1_ack_o, m1_err_o, m1_rty_o}, cse: {s_cyc_o, s_stb_o, s_we_o},
                      adr: s_adr_o, sel: s_sel_o, wd: s_dat_o, rd0: m0_dat_o, rd1: m1_dat_o};
                if (grant_o !== prev_g || (a.t0 | a.t1) != 3'b000) begin
                    n_cmp++;
                    if (expq.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event @%0d: got g=%b t0=%b t1=%b, want no event", cyc_n, a.g, a.t0, a.t1);
                    end else begin
                        e = expq.pop_front();
                        if (a !== e) begin
                            n_fail++;
                            $display("FAIL bus_event @%0d: got g=%b t0=%b t1=%b cse=%b adr=%h sel=%h wd=%h rd=%h/%h, want cyc=%0d g=%b t0=%b t1=%b cse=%b adr=%h sel=%h wd=%h rd=%h/%h",
                                     a.cyc, a.g, a.t0, a.t1, a.cse, a.adr, a.sel, a.wd, a.rd0, a.rd1,
                                     e.cyc, e.g, e.t0, e.t1, e.cse, e.adr, e.sel, e.wd, e.rd0, e.rd1);
                        end
                    end
                end
                prev_g = grant_o;
            end
        end
    end

endmodule
